// File: rtl/ahb_ctrl_slave.sv
// -----------------------------------------------------------------------------
// ahb_ctrl_slave
//
// AHB-Lite single-transfer responder for the CPU wake-up/control window.
// The external decoder asserts HSEL_i for the window; this block decodes the
// low OFS_W address bits into four word registers:
//
//   0x0 CTRL     [0] run (RW), [1] irq_en (RW, only with the IRQ build)
//   0x4 STATUS   [0] done (sticky, write-1-to-clear), [1] mbox_valid (RO)
//   0x8 MBOX_IN  host-to-CPU mailbox (RW), a write sets mbox_valid
//   0xC MBOX_OUT CPU-to-host mailbox (RO), host writes are ignored with OKAY
//
// Illegal transfers (offset >= 0x10, misaligned address, non-word size)
// receive the two-cycle ERROR response and change no register state.
//
// Parameters
//   WAIT_CYCLES  wait states inserted in every legal data phase (0..15)
//   OFS_W        local offset width taken from HADDR_i (4..31)
//
// Build option
//   AHB_CTRL_SLAVE_IRQ_EN  when defined, irq_o is the registered AND of
//                          STATUS.done and CTRL.irq_en; otherwise irq_o is
//                          tied low and CTRL[1] reads 0 / ignores writes.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   HSEL_i .. HREADY_i    AHB-Lite slave inputs (address and data phase)
//   HREADY_o, HRESP_o,
//   HRDATA_o              AHB-Lite slave responses, all registered
//   run_o                 CPU run enable (CTRL[0])
//   mbox_o                host-to-CPU mailbox contents
//   mbox_ack_i            CPU consumed mbox_o (pulse), clears mbox_valid
//   cpu_data_i/_we_i      CPU-to-host mailbox load
//   done_i                CPU done pulse, sets STATUS.done
//   irq_o                 interrupt to the host
// -----------------------------------------------------------------------------
module ahb_ctrl_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned OFS_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [31:0] HWDATA_i,
  input  logic        HREADY_i,
  output logic        HREADY_o,
  output logic [1:0]  HRESP_o,
  output logic [31:0] HRDATA_o,
  output logic        run_o,
  output logic [31:0] mbox_o,
  input  logic        mbox_ack_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_data_we_i,
  input  logic        done_i,
  output logic        irq_o
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  // Counter value loaded on entry to WAIT; the last wait cycle is cnt_q == 0.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

`ifdef AHB_CTRL_SLAVE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus-side state
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        dp_act_q;    // a legal transfer owns the current data phase
  logic        dp_write_q;
  logic [1:0]  dp_idx_q;    // register index of that transfer
  logic        hready_q;
  logic [1:0]  hresp_q;
  logic [31:0] hrdata_q;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic        run_q,        run_d;
  logic        irq_en_q,     irq_en_d;
  logic        done_q,       done_d;
  logic        mbox_valid_q, mbox_valid_d;
  logic [31:0] mbox_in_q,    mbox_in_d;
  logic [31:0] mbox_out_q,   mbox_out_d;

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic can_accept;
  logic ofs_hi_zero;
  logic legal;

  assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign accept     = can_accept & HSEL_i & HREADY_i & HTRANS_i[1];

  // Offset bits above the four-register window must be zero; address bits
  // above OFS_W belong to the external decoder and are ignored here.
  if (OFS_W > 4) begin : g_wide_ofs
    assign ofs_hi_zero = (HADDR_i[OFS_W-1:4] == '0);
  end else begin : g_narrow_ofs
    assign ofs_hi_zero = 1'b1;
  end

  assign legal = ofs_hi_zero && (HADDR_i[1:0] == 2'b00) && (HSIZE_i == SIZE_WORD);

  // Only NONSEQ/SEQ are distinguished via HTRANS_i[1]; the high address bits
  // are decoded outside this block.
  logic unused_bus;
  assign unused_bus = ^{HADDR_i[31:OFS_W], HTRANS_i[0]};

  // ---------------------------------------------------------------------------
  // Data-phase completion and host-write forwarding
  // ---------------------------------------------------------------------------
  // A data phase completes in the cycle this slave drives HREADY_o high while
  // a legal transfer is pending; the write commits on the edge ending it.
  logic complete;
  logic wr_en;
  logic wr_mbox;

  assign complete = hready_q & dp_act_q;
  assign wr_en    = complete & dp_write_q;
  assign wr_mbox  = wr_en && (dp_idx_q == 2'd2);

  // fwd_* is the register file as seen after the completing host write only.
  // Reads captured on the same edge use it, so a write followed immediately
  // by a read of the same register returns the new value, while CPU-side
  // events (done_i, mbox_ack_i, cpu_data_we_i) on that edge are not yet seen.
  logic        fwd_run;
  logic        fwd_irq_en;
  logic        fwd_done;
  logic        fwd_mbv;
  logic [31:0] fwd_mbin;
  logic [1:0]  rd_idx;
  logic [31:0] rd_data;

  // A zero-wait read is captured at the end of its address phase; a waited
  // read is captured at the end of its last wait cycle.
  assign rd_idx = (state_q == S_WAIT) ? dp_idx_q : HADDR_i[3:2];

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    fwd_run    = run_q;
    fwd_irq_en = irq_en_q;
    fwd_done   = done_q;
    fwd_mbv    = mbox_valid_q;
    fwd_mbin   = mbox_in_q;

    if (wr_en) begin
      unique case (dp_idx_q)
        2'd0: begin
          fwd_run    = HWDATA_i[0];
          fwd_irq_en = IRQ_EN ? HWDATA_i[1] : 1'b0;
        end
        2'd1: begin
          if (HWDATA_i[0]) fwd_done = 1'b0;
        end
        2'd2: begin
          fwd_mbin = HWDATA_i;
          fwd_mbv  = 1'b1;
        end
        default: ;  // MBOX_OUT is read-only from the bus
      endcase
    end

    rd_data = '0;
    unique case (rd_idx)
      2'd0: rd_data = {30'd0, fwd_irq_en, fwd_run};
      2'd1: rd_data = {30'd0, fwd_mbv, fwd_done};
      2'd2: rd_data = fwd_mbin;
      2'd3: rd_data = mbox_out_q;
    endcase

    // Next state = host view plus CPU-side events. A done_i set and a
    // mailbox write both win over a simultaneous clear.
    run_d        = fwd_run;
    irq_en_d     = fwd_irq_en;
    done_d       = fwd_done | done_i;
    mbox_valid_d = wr_mbox | (mbox_valid_q & ~mbox_ack_i);
    mbox_in_d    = fwd_mbin;
    mbox_out_d   = cpu_data_we_i ? cpu_data_i : mbox_out_q;
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM with registered HREADY_o / HRESP_o / HRDATA_o
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dp_act_q   <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= RESP_OKAY;
      hrdata_q   <= '0;
    end else begin
      // Read data is only non-zero in the cycle that completes a legal read.
      hrdata_q <= '0;

      unique case (state_q)
        S_IDLE, S_ERR2: begin
          state_q  <= S_IDLE;
          dp_act_q <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
          if (accept) begin
            if (legal) begin
              dp_act_q   <= 1'b1;
              dp_write_q <= HWRITE_i;
              dp_idx_q   <= HADDR_i[3:2];
              if (WAIT_CYCLES == 0) begin
                if (!HWRITE_i) hrdata_q <= rd_data;
              end else begin
                state_q  <= S_WAIT;
                cnt_q    <= WAIT_LAST;
                hready_q <= 1'b0;
              end
            end else begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= RESP_ERROR;
            end
          end
        end

        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            // Next cycle is the completion cycle; it is handled as IDLE so a
            // new address phase can be accepted alongside it.
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            if (!dp_write_q) hrdata_q <= rd_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= RESP_ERROR;
        end

        default: begin
          state_q  <= S_IDLE;
          dp_act_q <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= RESP_OKAY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      mbox_valid_q <= 1'b0;
      mbox_in_q    <= '0;
      mbox_out_q   <= '0;
    end else begin
      run_q        <= run_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      mbox_valid_q <= mbox_valid_d;
      mbox_in_q    <= mbox_in_d;
      mbox_out_q   <= mbox_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------------
`ifdef AHB_CTRL_SLAVE_IRQ_EN
  // Registered from the stored flags: rises one cycle after done sets.
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= done_q & irq_en_q;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign HREADY_o = hready_q;
  assign HRESP_o  = hresp_q;
  assign HRDATA_o = hrdata_q;
  assign run_o    = run_q;
  assign mbox_o   = mbox_in_q;

endmodule

// File: tb/tb_ahb_ctrl_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb_ctrl_slave
//
// Two instances share the bus and CPU-side inputs and are selected by tgt:
//   u_dut0  WAIT_CYCLES=0, OFS_W=4  (register function, errors, forwarding)
//   u_dut2  WAIT_CYCLES=2, OFS_W=5  (wait states, offset 0x10 out of range,
//                                    reset during a wait phase)
// Each instance's HREADY_o is looped back to its own HREADY_i.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_ahb_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        tgt;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        mbox_ack;
  logic [31:0] cpu_data;
  logic        cpu_we;
  logic        done_in;

  logic        hsel0, hready0, run0, irq0;
  logic [1:0]  hresp0;
  logic [31:0] hrdata0, mbox0;
  logic        hsel2, hready2, run2, irq2;
  logic [1:0]  hresp2;
  logic [31:0] hrdata2, mbox2;

  logic        hready_s;
  logic [1:0]  hresp_s;
  logic [31:0] hrdata_s;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [2:0] WORD   = 3'b010;

`ifdef AHB_CTRL_SLAVE_IRQ_EN
  localparam logic [31:0] CTRL3_RB = 32'h3;
  localparam logic [31:0] CTRL2_RB = 32'h2;
  localparam logic [31:0] IRQ_EXP  = 32'h1;
`else
  localparam logic [31:0] CTRL3_RB = 32'h1;
  localparam logic [31:0] CTRL2_RB = 32'h0;
  localparam logic [31:0] IRQ_EXP  = 32'h0;
`endif

  always #5 clk = ~clk;

  assign hsel0    = hsel & ~tgt;
  assign hsel2    = hsel & tgt;
  assign hready_s = tgt ? hready2 : hready0;
  assign hresp_s  = tgt ? hresp2  : hresp0;
  assign hrdata_s = tgt ? hrdata2 : hrdata0;

  ahb_ctrl_slave #(.WAIT_CYCLES(0), .OFS_W(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .HSEL_i(hsel0), .HADDR_i(haddr), .HTRANS_i(htrans),
    .HWRITE_i(hwrite), .HSIZE_i(hsize), .HWDATA_i(hwdata), .HREADY_i(hready0),
    .HREADY_o(hready0), .HRESP_o(hresp0), .HRDATA_o(hrdata0), .run_o(run0),
    .mbox_o(mbox0), .mbox_ack_i(mbox_ack), .cpu_data_i(cpu_data),
    .cpu_data_we_i(cpu_we), .done_i(done_in), .irq_o(irq0)
  );

  ahb_ctrl_slave #(.WAIT_CYCLES(2), .OFS_W(5)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .HSEL_i(hsel2), .HADDR_i(haddr), .HTRANS_i(htrans),
    .HWRITE_i(hwrite), .HSIZE_i(hsize), .HWDATA_i(hwdata), .HREADY_i(hready2),
    .HREADY_o(hready2), .HRESP_o(hresp2), .HRDATA_o(hrdata2), .run_o(run2),
    .mbox_o(mbox2), .mbox_ack_i(mbox_ack), .cpu_data_i(cpu_data),
    .cpu_data_we_i(cpu_we), .done_i(done_in), .irq_o(irq2)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock; single-cycle CPU-side pulses end here.
  task automatic tick();
    @(posedge clk); #1;
    done_in  = 1'b0;
    mbox_ack = 1'b0;
    cpu_we   = 1'b0;
  endtask

  // Single non-pipelined transfer to the instance picked by tgt. Returns in
  // the completion cycle (or after a bounded number of low-HREADY cycles).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic ap_we, input logic dp_done,
                      input logic dp_ack, output logic [31:0] rdata, output logic [1:0] resp,
                      output logic [1:0] resp0, output int waits);
    tick();
    hsel   = 1'b1;
    htrans = NONSEQ;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    cpu_we = ap_we;
    @(posedge clk); #1;
    cpu_we   = 1'b0;
    hsel     = 1'b0;
    htrans   = 2'b00;
    hwdata   = wdata;
    done_in  = dp_done;
    mbox_ack = dp_ack;
    resp0    = hresp_s;
    waits    = 0;
    while (hready_s !== 1'b1 && waits < 20) begin
      waits++;
      @(posedge clk); #1;
    end
    rdata = hrdata_s;
    resp  = hresp_s;
  endtask

  task automatic xfer_chk(input string name, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_waits, input logic ap_we, input logic dp_done,
                          input logic dp_ack);
    logic [31:0] rd;
    logic [1:0]  rs, rs0;
    int          w;
    logic [1:0]  exp_resp;
    exp_resp = exp_err ? 2'b01 : 2'b00;
    xfer(wr, addr, size, wdata, ap_we, dp_done, dp_ack, rd, rs, rs0, w);
    check({name, "_rdata"}, rd, exp_rdata);
    check({name, "_resp"}, 32'(rs), 32'(exp_resp));
    check({name, "_resp_first"}, 32'(rs0), 32'(exp_resp));
    check({name, "_waits"}, 32'(w), 32'(exp_err ? 1 : exp_waits));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tgt = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = WORD; hwdata = '0; mbox_ack = 1'b0; cpu_data = '0; cpu_we = 1'b0; done_in = 1'b0;

    // {wr, addr, size, wdata, expected HRDATA, expected ERROR}
    vecs[0]  = '{1'b1, 32'hC000_0008, WORD,   32'h0000_0003, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'hC000_0004, WORD,   32'h0,         32'h0000_0002, 1'b0};
    vecs[2]  = '{1'b0, 32'hC000_0008, WORD,   32'h0,         32'h0000_0003, 1'b0};
    vecs[3]  = '{1'b1, 32'hC000_000C, WORD,   32'h0000_0055, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'hC000_000C, WORD,   32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b1, 32'hC000_0002, WORD,   32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'hC000_0000, 3'b000, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'hC000_0000, 3'b000, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'hC000_0000, WORD,   32'h0,         32'h0000_0001, 1'b0};
    vecs[9]  = '{1'b1, 32'hC000_0000, WORD,   32'h0000_0003, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'hC000_0000, WORD,   32'h0,         CTRL3_RB,      1'b0};
    vecs[11] = '{1'b1, 32'hC000_0000, WORD,   32'h0000_0001, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'hC000_0004, WORD,   32'h0,         32'h0000_0002, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hready0", 32'(hready0), 32'h1);
    check("rst_hresp0", 32'(hresp0), 32'h0);
    check("rst_hrdata0", hrdata0, 32'h0);
    check("rst_run0", 32'(run0), 32'h0);
    check("rst_mbox0", mbox0, 32'h0);
    check("rst_irq0", 32'(irq0), 32'h0);
    check("rst_hready2", 32'(hready2), 32'h1);
    rst = 1'b0;

    // Write CTRL.run: zero-wait OKAY, run_o rises the cycle after completion
    xfer_chk("t1_wr_ctrl", 1'b1, 32'hC000_0000, WORD, 32'h1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t1_run_in_dphase", 32'(run0), 32'h0);
    tick();
    check("t1_run_after", 32'(run0), 32'h1);
    xfer_chk("t1_rd_ctrl", 1'b0, 32'hC000_0000, WORD, 32'h0, 32'h1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // done: sticky, W1C, set wins over clear
    tick();
    done_in = 1'b1;
    tick();
    xfer_chk("t2_rd_done", 1'b0, 32'hC000_0004, WORD, 32'h0, 32'h1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    xfer_chk("t2_w1c_set", 1'b1, 32'hC000_0004, WORD, 32'h1, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    xfer_chk("t2_rd_setwins", 1'b0, 32'hC000_0004, WORD, 32'h0, 32'h1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    xfer_chk("t2_w1c", 1'b1, 32'hC000_0004, WORD, 32'h1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    xfer_chk("t2_rd_cleared", 1'b0, 32'hC000_0004, WORD, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Register map and illegal-transfer table
    for (int i = 0; i < NV; i++) begin
      xfer_chk($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, 0, 1'b0, 1'b0, 1'b0);
    end
    check("t3_mbox_o", mbox0, 32'h3);
    check("t4_run_kept", 32'(run0), 32'h1);

    // Mailbox acknowledge and CPU-to-host mailbox
    tick();
    mbox_ack = 1'b1;
    tick();
    xfer_chk("t3_rd_status_ack", 1'b0, 32'hC000_0004, WORD, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cpu_data = 32'hDEAD_BEEF;
    cpu_we   = 1'b1;
    tick();
    xfer_chk("t3_rd_mbox_out", 1'b0, 32'hC000_000C, WORD, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cpu_data = 32'h1234_5678;
    xfer_chk("t3_rd_old_out", 1'b0, 32'hC000_000C, WORD, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    xfer_chk("t3_rd_new_out", 1'b0, 32'hC000_000C, WORD, 32'h0, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // MBOX_IN write with a simultaneous ack leaves mbox_valid set
    xfer_chk("t3_wr_mbox_ack", 1'b1, 32'hC000_0008, WORD, 32'h77, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    xfer_chk("t3_rd_valid_kept", 1'b0, 32'hC000_0004, WORD, 32'h0, 32'h2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t3_mbox_o_77", mbox0, 32'h77);

    // Back-to-back write then read of MBOX_IN
    tick();
    hsel = 1'b1; htrans = NONSEQ; haddr = 32'hC000_0008; hwrite = 1'b1; hsize = WORD;
    @(posedge clk); #1;
    check("b2b_wr_hready", 32'(hready0), 32'h1);
    hwdata = 32'hA5A5_0001;
    hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    check("b2b_rd_hready", 32'(hready0), 32'h1);
    check("b2b_rd_resp", 32'(hresp0), 32'h0);
    check("b2b_rd_data", hrdata0, 32'hA5A5_0001);
    check("b2b_mbox_o", mbox0, 32'hA5A5_0001);

    // Two wait states
    tgt = 1'b1;
    xfer_chk("w2_wr_ctrl", 1'b1, 32'hC000_0000, WORD, 32'h1, 32'h0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    xfer_chk("w2_rd_ctrl", 1'b0, 32'hC000_0000, WORD, 32'h0, 32'h1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    xfer_chk("w2_rd_ofs10", 1'b0, 32'hC000_0010, WORD, 32'h0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("w2_run2", 32'(run2), 32'h1);

    // IDLE and BUSY complete zero-wait with no read data
    for (int k = 0; k < 2; k++) begin
      tick();
      hsel = 1'b1; htrans = 2'(k); haddr = 32'hC000_0000; hwrite = 1'b0;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      check($sformatf("w2_idle%0d_hready", k), 32'(hready2), 32'h1);
      check($sformatf("w2_idle%0d_resp", k), 32'(hresp2), 32'h0);
      check($sformatf("w2_idle%0d_rdata", k), hrdata2, 32'h0);
    end

    // Reset during a wait phase drops the pending read
    tick();
    hsel = 1'b1; htrans = NONSEQ; haddr = 32'hC000_0000; hwrite = 1'b0; hsize = WORD;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    check("rw_in_wait", 32'(hready2), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rw_hready", 32'(hready2), 32'h1);
    check("rw_resp", 32'(hresp2), 32'h0);
    check("rw_rdata", hrdata2, 32'h0);
    check("rw_run2", 32'(run2), 32'h0);
    check("rw_mbox0", mbox0, 32'h0);
    rst = 1'b0;
    tick();
    check("rw_dropped_hready", 32'(hready2), 32'h1);
    check("rw_dropped_rdata", hrdata2, 32'h0);

    // Interrupt: rises one cycle after done sets, falls after W1C
    tgt = 1'b0;
    xfer_chk("irq_wr_ctrl", 1'b1, 32'hC000_0000, WORD, 32'h2, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    xfer_chk("irq_rd_ctrl", 1'b0, 32'hC000_0000, WORD, 32'h0, CTRL2_RB, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    done_in = 1'b1;
    tick();
    check("irq_latency", 32'(irq0), 32'h0);
    tick();
    check("irq_set", 32'(irq0), IRQ_EXP);
    xfer_chk("irq_w1c", 1'b1, 32'hC000_0004, WORD, 32'h1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("irq_before_clr", 32'(irq0), IRQ_EXP);
    tick();
    check("irq_clr_edge", 32'(irq0), IRQ_EXP);
    tick();
    check("irq_cleared", 32'(irq0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ctrl_slave.md
Name: ahb_ctrl_slave

Overview:
- AHB-Lite single-transfer responder (slave) for the CPU wake-up/control window at 0xC000_0000.
- Receives the NONSEQ single writes and reads that the host-side master issues.
- Drives CPU run control, a host-to-CPU mailbox, a CPU-to-host mailbox and a sticky done flag.
- Sits between the AHB slave port of the top-level FPGA wrapper and the CPU core; upper-address decode (HSEL_i) is external.

Parameters:
WAIT_CYCLES, 0, wait states inserted in every valid data phase (0..15)
OFS_W, 4, local offset width taken from HADDR_i[OFS_W-1:0]; 4 registers at 0x0/0x4/0x8/0xC

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
HSEL_i  in  1  slave select from external decoder
HADDR_i  in  32  address (only [OFS_W-1:0] used)
HTRANS_i  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE_i  in  1  1 = write
HSIZE_i  in  3  transfer size; only 3'b010 (word) legal
HWDATA_i  in  32  write data (data phase)
HREADY_i  in  1  bus HREADY (previous transfer complete)
HREADY_o  out  1  slave ready
HRESP_o  out  2  00 OKAY, 01 ERROR
HRDATA_o  out  32  read data, valid when HREADY_o=1 in a read data phase
run_o  out  1  CTRL[0], CPU run enable
mbox_o  out  32  host-to-CPU mailbox data
mbox_ack_i  in  1  CPU consumed mbox_o (pulse)
cpu_data_i  in  32  CPU-to-host mailbox data
cpu_data_we_i  in  1  load cpu_data_i into MBOX_OUT
done_i  in  1  CPU done pulse
irq_o  out  1  interrupt (feature-dependent)

Behaviour:
- Register map:
  - 0x0 CTRL: [0] run, RW; [1] irq_en, RW.
  - 0x4 STATUS: [0] done, sticky, W1C; [1] mbox_valid, RO; other bits read 0.
  - 0x8 MBOX_IN: RW; write sets mbox_valid.
  - 0xC MBOX_OUT: RO; writes are ignored with OKAY.
- Address phase is accepted when HSEL_i & HREADY_i & HTRANS_i[1]. Latch write, offset, size and legality.
- IDLE or BUSY, or not selected: the next data phase is zero-wait OKAY with no side effects.
- Illegal transfer = offset >= 0x10 (HADDR_i[31:OFS_W] ignored), HADDR_i[1:0]!=0, or HSIZE_i!=3'b010.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADY_o=1, HRESP_o=OKAY. On an accepted legal transfer: go to WAIT if WAIT_CYCLES>0, else complete this data phase with zero wait. On an accepted illegal transfer, go to ERR1.
  - WAIT: HREADY_o=0 for exactly WAIT_CYCLES cycles, then HREADY_o=1 OKAY completion cycle, then IDLE (or a new accept in the same cycle).
  - ERR1: HREADY_o=0, HRESP_o=01.
  - ERR2: HREADY_o=1, HRESP_o=01. Accept a new address phase the same as IDLE.
  - No register state changes on ERROR.
- Write side effect: registered on the clock edge ending the completing data phase (HREADY_o=1), using HWDATA_i. Visible on run_o/mbox_o the next cycle.
- Read: HRDATA_o is registered and valid in the completing cycle. It is 0 in all other cycles and for errors.
- Back-to-back: a write followed immediately by a read of the same register returns the new value.
- done: set by done_i. A W1C write of 1 with done_i high in the same cycle leaves done=1 (set wins).
- mbox_valid: set by a MBOX_IN write, cleared by mbox_ack_i. Simultaneous write and ack gives mbox_valid=1.
- MBOX_OUT: loaded when cpu_data_we_i=1. A host read in the same cycle returns the old value.
- Reset, including mid-WAIT or mid-ERR:
  - FSM goes to IDLE, HREADY_o=1, HRESP_o=00, HRDATA_o=0.
  - run_o=0, mbox_o=0, MBOX_OUT=0, done=0, mbox_valid=0, irq_en=0, irq_o=0.
  - A pending transfer is dropped.

Optional Feature:
- Macro AHB_CTRL_SLAVE_IRQ_EN.
  - Defined: irq_o = registered (done & CTRL[1]), with 1 cycle latency from done setting.
  - Undefined: irq_o tied 0; CTRL[1] reads 0 and writes to it are ignored.

Test Plan:
1. Reset, then write 0x0000_0001 to 0xC000_0000 (NONSEQ, word, WAIT_CYCLES=0) -> HREADY_o stays 1, HRESP_o=00; run_o=1 one cycle after the data phase; read 0x0 -> HRDATA_o=0x0000_0001.
2. Pulse done_i, then read 0x4 -> 0x0000_0001. Write 0x1 to 0x4 while done_i is pulsed -> done stays 1. Write 0x1 again with done_i low -> read returns 0x0.
3. Write 0x0000_0003 to 0x8 -> mbox_o=3, STATUS=0x2. Pulse mbox_ack_i -> STATUS=0x0. cpu_data_we_i with 0xDEAD_BEEF -> read 0xC returns 0xDEAD_BEEF.
4. Illegal transfers each produce HREADY_o 0 then 1 with HRESP_o=01 on both cycles, and no register change:
   - Read 0x10.
   - Write 0x2.
   - HSIZE_i=3'b000 to 0x0.
5. WAIT_CYCLES=2, read 0x0 -> HREADY_o low exactly 2 cycles, then high with correct data; an IDLE transfer still completes zero-wait.
6. Assert rst_i during a WAIT phase -> next cycle HREADY_o=1, HRESP_o=00, run_o=0; with the macro defined, done & irq_en -> irq_o=1 one cycle later, and deasserts after W1C.
